instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the lock-in warp decoder.
- Accepts structured micro-op descriptions from the host/test loader over a valid/ready stream.
- Encodes each into a 32-bit instruction word in the exact field layout the decoder expects.
- Writes the words sequentially into instruction memory through a write handshake.
- Range-checks every field, counts words, and flags the end of a program load when EXIT is written.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width.
- BASE_ADDR, 0, first write address of each load session.
- DEPTH, 256, maximum words per session (≤ 2^ADDR_WIDTH).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  pulse; opens a load session.
- in_valid  input  1  micro-op valid.
- in_ready  output  1  micro-op accepted when in_valid && in_ready.
- in_class  input  4  0=R 1=I 2=F 3=LW 4=SW 5=FLW 6=FSW 7=LUI 8=JAL 9=BEQZ 10=SYNC 11=EXIT.
- in_funct  input  4  ALU funct4 for the R, I and F classes.
- in_rd, in_rs1, in_rs2  input  5 each  register addresses.
- in_imm  input  32  signed immediate; for LUI, the full 32-bit value.
- in_scalar  input  1  scalar (1) or vector (0) instruction.
- mem_valid  output  1  write request.
- mem_ready  input  1  memory accepts the write.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_data  output  32  encoded word.
- busy  output  1  session in progress.
- done  output  1  EXIT word has been written.
- err  output  1  sticky error.
- err_code  output  2  first error: 1=bad class/funct, 2=immediate out of range, 3=overflow.
- count  output  ADDR_WIDTH+1  words written this session.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; mem_valid=0, mem_addr=BASE_ADDR, mem_data=0, busy=0, done=0, err=0, err_code=0, count=0, in_ready=0. Reset mid-transfer drops mem_valid immediately; the pending word is lost.
- States:
  - IDLE --start--> LOAD.
  - LOAD --EXIT word handshaken--> DONE.
  - DONE --start--> LOAD.
  - start in LOAD is ignored.
  - Entering LOAD clears count, err, err_code and done, and sets the next address to BASE_ADDR.
- busy=1 only in LOAD; done=1 only in DONE.
- in_ready = (state==LOAD) && !exit_seen && (!mem_valid || mem_ready) && count_pending < DEPTH.
- Latency: an accepted legal micro-op drives mem_valid with its word on the next cycle.
  - mem_valid, mem_addr and mem_data are held stable until mem_ready.
  - On handshake: count+1 and address+1. Back-to-back throughput is 1 word/cycle.
- Encoding (bit positions):
  - opcode [31:29] uses the `OPCODE_* macros from common.sv. All unspecified bits are 0.
  - R/F: rd[4:0], rs1[9:5], funct4[13:10], rs2[18:14], scalar[28].
  - I: rd, rs1, funct4[13:10], imm[13:0]→[27:14], scalar[28].
  - LW/FLW: funct3 000/010 at [12:10]; rd, rs1, scalar[13]; imm[14:0]→[28:14].
  - SW/FSW: funct3 001/011; rs1, rs2, scalar[13]; imm[14:5]→[28:19], imm[4:0]→[4:0].
  - LUI: rd[4:0], scalar[5], imm[31:12]→[28:9].
  - J group (funct3 at [12:10]):
    - JAL 000: imm[25:10]→[28:13], imm[9:0]→[9:0].
    - BEQZ 001: rs1, rs2; imm[15:6]→[28:19], imm[5]→[13], imm[4:0]→[4:0].
    - SYNC 110: no other fields.
    - EXIT 111: no other fields.
- Legality:
  - Legal funct4 values: R 0–9; I 0, 2, 3 or 10; F 0–10.
  - class > 11 is illegal.
  - Immediate must sign-fit: I 14 bits; loads/stores 15; BEQZ 16; JAL 26.
  - LUI requires imm[11:0]==0.
- An illegal micro-op is still accepted (in_ready handshake completes) but not written. It sets err, and sets err_code only if err_code==0.
- Overflow: when count + pending == DEPTH, in_ready stays 0. A further in_valid while at DEPTH sets err with code 3. The address never wraps.
- After the EXIT word handshakes, further in_valid is refused until the next start.

Test Plan:
- start, then R ADD (funct 0, rd=3, rs1=1, rs2=2, scalar=0) → next cycle mem_valid=1, mem_addr=0, mem_data=(`OPCODE_R<<29)|0x00008023; count=1 after mem_ready.
- I ADDI (rd=5, rs1=0, imm=-1) then LUI (rd=1, imm=0x12345000, scalar=1) back-to-back with mem_ready=1 → words (`OPCODE_I<<29)|0x0FFFC005 and (`OPCODE_UP<<29)|0x02468A21 at addresses 0 and 1, with no bubble.
- mem_ready held 0 for 5 cycles → mem_data/mem_addr stable and in_ready=0 throughout; the word commits on the first ready cycle.
- I class with imm=8192 → no write, err=1, err_code=2; a following F funct 11 leaves err_code=2 and performs no write.
- EXIT → mem_data=(`OPCODE_J<<29)|0x00001C00; done=1, busy=0 after the handshake; a new start clears done and count, and restarts at BASE_ADDR.
- DEPTH=4: stream 5 legal micro-ops → 4 written, in_ready=0, err_code=3. A reset pulse mid-stall → all outputs return to their reset values.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Micro-op encoder and instruction-memory loader.
// Takes structured micro-ops from the host loader, range-checks them, packs
// each into the 32-bit word layout the warp decoder expects, and streams the
// words into instruction memory starting at BASE_ADDR for each load session.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | after reset, waiting for the first start pulse
//   S_LOAD | session open: accept micro-ops, write encoded words
//   S_DONE | EXIT word has been written; waiting for the next start pulse

`ifndef OPCODE_R
`define OPCODE_R  3'b001
`endif
`ifndef OPCODE_I
`define OPCODE_I  3'b010
`endif
`ifndef OPCODE_F
`define OPCODE_F  3'b011
`endif
`ifndef OPCODE_M
`define OPCODE_M  3'b100
`endif
`ifndef OPCODE_UP
`define OPCODE_UP 3'b101
`endif
`ifndef OPCODE_J
`define OPCODE_J  3'b110
`endif

module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_class,
    input  logic [3:0]            in_funct,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    input  logic                  in_scalar,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [2:0] OP_R  = `OPCODE_R;
    localparam logic [2:0] OP_I  = `OPCODE_I;
    localparam logic [2:0] OP_F  = `OPCODE_F;
    localparam logic [2:0] OP_M  = `OPCODE_M;
    localparam logic [2:0] OP_UP = `OPCODE_UP;
    localparam logic [2:0] OP_J  = `OPCODE_J;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] BASE_W   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    localparam logic [1:0] ERR_FIELD = 2'd1;
    localparam logic [1:0] ERR_IMM   = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                exit_seen;
    logic                open_session;
    logic                overflow_req;
    logic                handshake;
    logic                accept;
    logic [ADDR_WIDTH:0] count_pending;
    logic [31:0]         word;
    logic [1:0]          bad_code;
    logic                is_exit;

    // True when v, read as a signed value, fits in n bits two's complement.
    function automatic logic sign_fits(input logic [31:0] v, input int unsigned n);
        logic signed [31:0] sh;
        sh = $signed(v) >>> (n - 1);
        return (sh == '0) || (sh == '1);
    endfunction

    assign handshake     = mem_valid && mem_ready;
    assign accept        = in_valid && in_ready;
    assign count_pending = count + {{ADDR_WIDTH{1'b0}}, mem_valid};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, status outputs and input flow control.
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        in_ready     = 1'b0;
        open_session = 1'b0;
        overflow_req = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt    = S_LOAD;
                    open_session = 1'b1;
                end
            end
            S_LOAD: begin
                busy         = 1'b1;
                in_ready     = !exit_seen && (!mem_valid || mem_ready)
                               && (count_pending < DEPTH_W);
                overflow_req = !exit_seen && in_valid && (count_pending >= DEPTH_W);
                // exit_seen blocks new accepts, so the word completing here is EXIT
                if (handshake && exit_seen) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt    = S_LOAD;
                    open_session = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Field packing and legality check for the micro-op on the input bus.
    always_comb begin
        word     = '0;
        bad_code = 2'd0;
        is_exit  = 1'b0;
        case (in_class)
            4'd0, 4'd2: begin
                word[31:29] = (in_class == 4'd0) ? OP_R : OP_F;
                word[4:0]   = in_rd;
                word[9:5]   = in_rs1;
                word[13:10] = in_funct;
                word[18:14] = in_rs2;
                word[28]    = in_scalar;
                if ((in_class == 4'd0 && in_funct > 4'd9) ||
                    (in_class == 4'd2 && in_funct > 4'd10)) begin
                    bad_code = ERR_FIELD;
                end
            end
            4'd1: begin
                word[31:29] = OP_I;
                word[4:0]   = in_rd;
                word[9:5]   = in_rs1;
                word[13:10] = in_funct;
                word[27:14] = in_imm[13:0];
                word[28]    = in_scalar;
                if (!(in_funct == 4'd0 || in_funct == 4'd2 ||
                      in_funct == 4'd3 || in_funct == 4'd10)) begin
                    bad_code = ERR_FIELD;
                end else if (!sign_fits(in_imm, 14)) begin
                    bad_code = ERR_IMM;
                end
            end
            4'd3, 4'd5: begin
                word[31:29] = OP_M;
                word[12:10] = (in_class == 4'd5) ? 3'b010 : 3'b000;
                word[4:0]   = in_rd;
                word[9:5]   = in_rs1;
                word[13]    = in_scalar;
                word[28:14] = in_imm[14:0];
                if (!sign_fits(in_imm, 15)) begin
                    bad_code = ERR_IMM;
                end
            end
            4'd4, 4'd6: begin
                word[31:29] = OP_M;
                word[12:10] = (in_class == 4'd6) ? 3'b011 : 3'b001;
                word[9:5]   = in_rs1;
                word[18:14] = in_rs2;
                word[13]    = in_scalar;
                word[28:19] = in_imm[14:5];
                word[4:0]   = in_imm[4:0];
                if (!sign_fits(in_imm, 15)) begin
                    bad_code = ERR_IMM;
                end
            end
            4'd7: begin
                word[31:29] = OP_UP;
                word[4:0]   = in_rd;
                word[5]     = in_scalar;
                word[28:9]  = in_imm[31:12];
                if (in_imm[11:0] != 12'd0) begin
                    bad_code = ERR_IMM;
                end
            end
            4'd8: begin
                word[31:29] = OP_J;
                word[12:10] = 3'b000;
                word[28:13] = in_imm[25:10];
                word[9:0]   = in_imm[9:0];
                if (!sign_fits(in_imm, 26)) begin
                    bad_code = ERR_IMM;
                end
            end
            4'd9: begin
                word[31:29] = OP_J;
                word[12:10] = 3'b001;
                word[9:5]   = in_rs1;
                word[18:14] = in_rs2;
                word[28:19] = in_imm[15:6];
                word[13]    = in_imm[5];
                word[4:0]   = in_imm[4:0];
                if (!sign_fits(in_imm, 16)) begin
                    bad_code = ERR_IMM;
                end
            end
            4'd10: begin
                word[31:29] = OP_J;
                word[12:10] = 3'b110;
            end
            4'd11: begin
                word[31:29] = OP_J;
                word[12:10] = 3'b111;
                is_exit     = 1'b1;
            end
            default: bad_code = ERR_FIELD;
        endcase
    end

    // Write port, word counter, address pointer and sticky error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_valid <= 1'b0;
            mem_addr  <= BASE_W;
            mem_data  <= '0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            count     <= '0;
            exit_seen <= 1'b0;
        end else if (open_session) begin
            mem_valid <= 1'b0;
            mem_addr  <= BASE_W;
            err       <= 1'b0;
            err_code  <= 2'd0;
            count     <= '0;
            exit_seen <= 1'b0;
        end else begin
            if (handshake) begin
                mem_valid <= 1'b0;
                count     <= count + CNT_ONE;
                if (mem_addr != ADDR_MAX) begin
                    mem_addr <= mem_addr + ADDR_ONE;
                end
            end
            if (accept) begin
                if (bad_code == 2'd0) begin
                    mem_valid <= 1'b1;
                    mem_data  <= word;
                    if (is_exit) begin
                        exit_seen <= 1'b1;
                    end
                end else begin
                    err <= 1'b1;
                    if (err_code == 2'd0) begin
                        err_code <= bad_code;
                    end
                end
            end else if (overflow_req) begin
                err <= 1'b1;
                if (err_code == 2'd0) begin
                    err_code <= ERR_OVF;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a default-size instance for the
// encoding/handshake cases and a DEPTH=4 instance for the overflow case.
// Both instances share the same stimulus.

module tb_instr_encoder_loader;

    localparam logic [31:0] OPC_R  = 32'h2000_0000;
    localparam logic [31:0] OPC_I  = 32'h4000_0000;
    localparam logic [31:0] OPC_M  = 32'h8000_0000;
    localparam logic [31:0] OPC_UP = 32'hA000_0000;
    localparam logic [31:0] OPC_J  = 32'hC000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_class;
    logic [3:0]  in_funct;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_scalar;
    logic        mem_ready;

    logic        in_ready;
    logic        mem_valid;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [8:0]  count;

    logic        s_in_ready;
    logic        s_mem_valid;
    logic [7:0]  s_mem_addr;
    logic [31:0] s_mem_data;
    logic        s_busy;
    logic        s_done;
    logic        s_err;
    logic [1:0]  s_err_code;
    logic [8:0]  s_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_encoder_loader u_dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct(in_funct),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_scalar(in_scalar),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .count(count)
    );

    instr_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0), .DEPTH(4)) u_small (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_class(in_class), .in_funct(in_funct),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_scalar(in_scalar),
        .mem_valid(s_mem_valid), .mem_ready(mem_ready),
        .mem_addr(s_mem_addr), .mem_data(s_mem_data),
        .busy(s_busy), .done(s_done), .err(s_err), .err_code(s_err_code),
        .count(s_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] c, input logic [3:0] f, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input logic sc);
        in_class  = c;
        in_funct  = f;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_scalar = sc;
    endtask

    task automatic new_session();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One-cycle accept with mem_ready=1; checks the word, then lets it commit.
    task automatic send_chk(input string tag, input logic [31:0] exp);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check(tag, {31'd0, mem_valid, mem_data}, {31'd0, 1'b1, exp});
        tick();
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        mem_ready = 1'b0;
        set_op(4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        tick();
        tick();

        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_mem_addr",  mem_addr,  8'd0);
        check("rst_mem_data",  mem_data,  32'd0);
        check("rst_flags",     {busy, done, err, in_ready}, 4'b0000);
        check("rst_err_code",  err_code,  2'd0);
        check("rst_count",     count,     9'd0);

        // single R word, held until memory accepts it
        new_session();
        check("load_busy",     busy,     1'b1);
        check("load_in_ready", in_ready, 1'b1);
        set_op(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("r_valid", mem_valid, 1'b1);
        check("r_addr",  mem_addr,  8'd0);
        check("r_data",  mem_data,  OPC_R | 32'h0000_8023);
        check("r_count_pre", count, 9'd0);
        mem_ready = 1'b1;
        tick();
        check("r_count", count, 9'd1);
        check("r_idle",  mem_valid, 1'b0);
        check("r_next_addr", mem_addr, 8'd1);

        // back-to-back I then LUI with memory always ready
        new_session();
        set_op(4'd1, 4'd0, 5'd5, 5'd0, 5'd0, -32'sd1, 1'b0);
        in_valid = 1'b1;
        tick();
        check("addi_data", mem_data, OPC_I | 32'h0FFF_C005);
        check("addi_addr", mem_addr, 8'd0);
        check("addi_ready", in_ready, 1'b1);
        set_op(4'd7, 4'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
        tick();
        in_valid = 1'b0;
        check("lui_valid", mem_valid, 1'b1);
        check("lui_data",  mem_data,  OPC_UP | 32'h0246_8A21);
        check("lui_addr",  mem_addr,  8'd1);
        check("lui_count_pre", count, 9'd1);
        tick();
        check("b2b_count", count, 9'd2);

        // five-cycle memory stall
        mem_ready = 1'b0;
        set_op(4'd0, 4'd9, 5'd31, 5'd31, 5'd31, 32'd0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {mem_valid, in_ready, mem_addr, mem_data},
                  {1'b1, 1'b0, 8'd2, OPC_R | 32'h1007_E7FF});
            tick();
        end
        mem_ready = 1'b1;
        tick();
        check("stall_commit", {mem_valid, count}, {1'b0, 9'd3});

        // illegal immediate then illegal funct: first code sticks, nothing written
        set_op(4'd1, 4'd0, 5'd0, 5'd0, 5'd0, 32'd8192, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("imm_err", {mem_valid, err, err_code}, {1'b0, 1'b1, 2'd2});
        set_op(4'd2, 4'd11, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("funct_err", {mem_valid, err, err_code}, {1'b0, 1'b1, 2'd2});
        tick();
        check("err_no_write", count, 9'd3);

        // boundary immediates in each format
        set_op(4'd1, 4'd10, 5'd1, 5'd2, 5'd0, -32'sd8192, 1'b0);
        send_chk("i_min_imm", OPC_I | 32'h0800_2841);
        set_op(4'd5, 4'd0, 5'd2, 5'd4, 5'd0, -32'sd16384, 1'b1);
        send_chk("flw", OPC_M | 32'h1000_2882);
        set_op(4'd4, 4'd0, 5'd0, 5'd7, 5'd9, 32'd16383, 1'b0);
        send_chk("sw", OPC_M | 32'h0FFA_44FF);
        set_op(4'd9, 4'd0, 5'd0, 5'd1, 5'd2, -32'sd2, 1'b0);
        send_chk("beqz", OPC_J | 32'h1FF8_A43E);
        set_op(4'd8, 4'd0, 5'd0, 5'd0, 5'd0, 32'h01FF_FFFF, 1'b0);
        send_chk("jal", OPC_J | 32'h0FFF_E3FF);
        check("pre_exit_addr", mem_addr, 8'd8);

        // EXIT closes the session
        set_op(4'd11, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        send_chk("exit", OPC_J | 32'h0000_1C00);
        check("exit_state", {done, busy, in_ready}, 3'b100);
        check("exit_count", count, 9'd9);
        set_op(4'd0, 4'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("after_exit_refused", {mem_valid, count}, {1'b0, 9'd9});
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart", {done, busy, err, err_code, count, mem_addr},
              {1'b0, 1'b1, 1'b0, 2'd0, 9'd0, 8'd0});

        // DEPTH=4 instance: five legal ops offered, four written
        new_session();
        mem_ready = 1'b1;
        set_op(4'd0, 4'd1, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
        in_valid = 1'b1;
        repeat (7) tick();
        check("ovf_count",   s_count,    9'd4);
        check("ovf_ready",   s_in_ready, 1'b0);
        check("ovf_err",     {s_err, s_err_code}, {1'b1, 2'd3});
        check("ovf_addr",    {s_mem_valid, s_mem_addr}, {1'b0, 8'd4});
        in_valid = 1'b0;

        // reset in the middle of a stalled write
        new_session();
        mem_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("stall_pending", s_mem_valid, 1'b1);
        reset = 1'b0;
        tick();
        check("midrst_outputs",
              {s_mem_valid, s_in_ready, s_busy, s_done, s_err, s_err_code, s_count, s_mem_addr},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 9'd0, 8'd0});
        check("midrst_data", s_mem_data, 32'd0);
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
